// File: rtl/hp_iir_mc.sv
// hp_iir_mc: time-multiplexed first-order DC-blocking high-pass IIR.
//   y[n] = x[n] - x[n-1] + ((a * y[n-1]) >>> FRAC), per channel, one cycle latency.
// Optional feature macro HP_IIR_SAT_EN: clamp the result to the DW-bit range and
// raise sat_flag; when undefined the result wraps and sat_flag stays 0.
module hp_iir_mc #(
   parameter int DW       = 8,
   parameter int CW       = 8,
   parameter int FRAC     = 6,
   parameter int NCH      = 2,
   parameter int COEF_RST = 60,
   localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [CHW-1:0]        in_ch,
   input  logic signed [DW-1:0]  d_in,
   input  logic                  coef_load,
   input  logic signed [CW-1:0]  coef_in,
   input  logic                  clr,
   output logic                  out_valid,
   output logic [CHW-1:0]        out_ch,
   output logic signed [DW-1:0]  d_out,
   output logic                  sat_flag
);

   localparam int PW = DW + CW;
   localparam int SW = DW + CW + 2;

   localparam logic signed [SW-1:0] MAX_S = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [SW-1:0] MIN_S = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   // Limit the full-precision sum to DW bits (clamp or wrap).
   function automatic logic signed [DW-1:0] lim_f(input logic signed [SW-1:0] s);
`ifdef HP_IIR_SAT_EN
      if (s > MAX_S)      return MAX_S[DW-1:0];
      else if (s < MIN_S) return MIN_S[DW-1:0];
      else                return DW'(s);
`else
      return DW'(s);
`endif
   endfunction

`ifdef HP_IIR_SAT_EN
   // True when the sum lies outside the DW-bit signed range.
   function automatic logic ovf_f(input logic signed [SW-1:0] s);
      return (s > MAX_S) || (s < MIN_S);
   endfunction
`endif

   // Per-channel state and the active feedback coefficient.
   logic signed [DW-1:0] x_st [NCH];
   logic signed [DW-1:0] y_st [NCH];
   logic [NCH-1:0]       prm_st;
   logic signed [CW-1:0] coef;

   // ---- stage p0: combinational datapath from d_in and channel state ----
   logic                 ch_ok;
   logic                 vld_p0;
   logic signed [DW-1:0] xl_p0;
   logic signed [DW-1:0] yl_p0;
   logic                 prm_p0;
   logic signed [PW-1:0] prod_p0;
   logic signed [PW-1:0] shf_p0;
   logic signed [SW-1:0] sum_p0;
   logic signed [DW-1:0] y_p0;
   logic                 sat_p0;

   // When NCH fills the index space every index is legal.
   generate
      if (NCH == (1 << CHW)) begin : g_full
         assign ch_ok = 1'b1;
      end else begin : g_part
         assign ch_ok = (int'(in_ch) < NCH);
      end
   endgenerate

   assign vld_p0 = in_valid & ch_ok & ~clr;

   // Fetch the addressed channel's state; out-of-range reads are never committed.
   always_comb begin
      xl_p0  = x_st[in_ch];
      yl_p0  = y_st[in_ch];
      prm_p0 = prm_st[in_ch];
   end

   assign prod_p0 = PW'(coef) * PW'(yl_p0);
   assign shf_p0  = prod_p0 >>> FRAC;
   assign sum_p0  = SW'(d_in) - SW'(xl_p0) + SW'(shf_p0);
   assign y_p0    = prm_p0 ? lim_f(sum_p0) : '0;
`ifdef HP_IIR_SAT_EN
   assign sat_p0  = prm_p0 & ovf_f(sum_p0);
`else
   assign sat_p0  = 1'b0;
`endif

   // ---- stage p1: registered outputs, channel state and coefficient ----
   // Commit accepted samples; clr wipes channel state, never the coefficient.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_ch    <= '0;
         d_out     <= '0;
         sat_flag  <= 1'b0;
         coef      <= CW'(COEF_RST);
         prm_st    <= '0;
         for (int i = 0; i < NCH; i++) begin
            x_st[i] <= '0;
            y_st[i] <= '0;
         end
      end else begin
         out_valid <= vld_p0;
         if (coef_load) coef <= coef_in;
         if (clr) begin
            prm_st <= '0;
            for (int i = 0; i < NCH; i++) begin
               x_st[i] <= '0;
               y_st[i] <= '0;
            end
         end else if (vld_p0) begin
            out_ch         <= in_ch;
            d_out          <= y_p0;
            sat_flag       <= sat_p0;
            x_st[in_ch]    <= d_in;
            y_st[in_ch]    <= y_p0;
            prm_st[in_ch]  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hp_iir_mc.sv
// Directed bench for hp_iir_mc (DW=8, CW=8, FRAC=6, NCH=2, reset coefficient 60).
module tb_hp_iir_mc;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic [0:0]        in_ch;
   logic signed [7:0] d_in;
   logic              coef_load;
   logic signed [7:0] coef_in;
   logic              clr;
   logic              out_valid;
   logic [0:0]        out_ch;
   logic signed [7:0] d_out;
   logic              sat_flag;

   int checks   = 0;
   int failures = 0;

   hp_iir_mc #(.DW(8), .CW(8), .FRAC(6), .NCH(2), .COEF_RST(60)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .d_in(d_in),
      .coef_load(coef_load), .coef_in(coef_in), .clr(clr),
      .out_valid(out_valid), .out_ch(out_ch), .d_out(d_out), .sat_flag(sat_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs at the falling edge, then sample 1 ns after the rising edge.
   task automatic step(input logic v, input logic [0:0] ch, input logic signed [7:0] d,
                       input logic ld, input logic signed [7:0] ci, input logic cl);
      @(negedge clk);
      in_valid  = v;
      in_ch     = ch;
      d_in      = d;
      coef_load = ld;
      coef_in   = ci;
      clr       = cl;
      @(posedge clk);
      #1;
   endtask

   task automatic smp(input string tag, input logic [0:0] ch, input logic signed [7:0] d,
                      input int exp_d);
      step(1'b1, ch, d, 1'b0, 8'sd0, 1'b0);
      chk({tag, "_vld"}, int'(out_valid), 1);
      chk({tag, "_ch"}, int'(out_ch), int'(ch));
      chk({tag, "_d"}, int'(d_out), exp_d);
   endtask

   task automatic do_clr();
      step(1'b0, 1'b0, 8'sd0, 1'b0, 8'sd0, 1'b1);
      chk("clr_vld", int'(out_valid), 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; d_in = '0;
      coef_load = 1'b0; coef_in = '0; clr = 1'b0;
      #12;
      chk("rst_vld", int'(out_valid), 0);
      chk("rst_d", int'(d_out), 0);
      chk("rst_sat", int'(sat_flag), 0);
      @(negedge clk) rst_n = 1'b1;

      // first sample after reset is unprimed, second equal sample gives 0
      smp("r50a", 1'b0, 8'sd50, 0);
      smp("r50b", 1'b0, 8'sd50, 0);

      // step response
      do_clr();
      smp("st0", 1'b0, 8'sd0, 0);
      smp("st1", 1'b0, 8'sd64, 64);
      smp("st2", 1'b0, 8'sd64, 60);
      smp("st3", 1'b0, 8'sd64, 56);
      step(1'b0, 1'b0, 8'sd0, 1'b0, 8'sd0, 1'b0);
      chk("idle_vld", int'(out_valid), 0);
      chk("idle_hold", int'(d_out), 56);

      // output limit
      do_clr();
      smp("lim0", 1'b0, -8'sd128, 0);
`ifdef HP_IIR_SAT_EN
      smp("lim1", 1'b0, 8'sd127, 127);
      chk("lim1_sat", int'(sat_flag), 1);
`else
      smp("lim1", 1'b0, 8'sd127, -1);
      chk("lim1_sat", int'(sat_flag), 0);
`endif

      // interleaved channels
      do_clr();
      smp("il0a", 1'b0, 8'sd0, 0);
      smp("il1a", 1'b1, 8'sd0, 0);
      smp("il0b", 1'b0, 8'sd64, 64);
      smp("il1b", 1'b1, 8'sd10, 10);
      smp("il0c", 1'b0, 8'sd64, 60);
      smp("il1c", 1'b1, 8'sd10, 9);
      chk("il1c_sat", int'(sat_flag), 0);

      // clr drops a same-cycle sample and unprimes the channel
      step(1'b1, 1'b0, 8'sd64, 1'b0, 8'sd0, 1'b1);
      chk("clrsmp_vld", int'(out_valid), 0);
      smp("clr0", 1'b0, 8'sd0, 0);

      // coefficient load: same-cycle sample keeps old coefficient
      smp("cf0", 1'b0, 8'sd64, 64);
      step(1'b1, 1'b0, 8'sd64, 1'b1, 8'sd32, 1'b0);
      chk("cf1_vld", int'(out_valid), 1);
      chk("cf1_d", int'(d_out), 60);
      smp("cf2", 1'b0, 8'sd64, 30);

      // clr keeps the new coefficient
      do_clr();
      smp("cc0", 1'b0, 8'sd0, 0);
      smp("cc1", 1'b0, 8'sd64, 64);
      smp("cc2", 1'b0, 8'sd64, 32);
      smp("cc3", 1'b0, 8'sd0, -48);
      smp("cc4", 1'b0, 8'sd0, -24);

      // mid-stream asynchronous reset, sample present while reset is low
      @(negedge clk);
      in_valid = 1'b1; in_ch = 1'b0; d_in = 8'sd64;
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_vld", int'(out_valid), 0);
      chk("mrst_d", int'(d_out), 0);
      chk("mrst_sat", int'(sat_flag), 0);
      @(posedge clk); #1;
      chk("mrst_hold", int'(out_valid), 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      smp("mr0", 1'b0, 8'sd0, 0);
      smp("mr1", 1'b0, 8'sd64, 64);
      smp("mr2", 1'b0, 8'sd64, 60);
      smp("mr3", 1'b0, 8'sd0, -8);
      smp("mr4", 1'b0, 8'sd0, -8);
      smp("mr5", 1'b1, 8'sd20, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
